fse_ctrl: RTL

Sequencing and configuration controller for the fractionally spaced equalizer (FSE) complex FIR. It produces the sample-rate shift enable that drives the equalizer delay line, and the symbol-rate decimation strobe that feeds the slicer and the LMS adaptation logic. It holds the double-buffered I/Q tap bank that drives the equalizer's packed tap inputs. It also schedules the start-up fill, training-to-tracking step-size transition and stop/restart. The block sits between the receiver control registers and the FSE datapath.

---
 rtl/fse_ctrl.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/fse_ctrl.sv
// FSE sequencing controller: sample/symbol strobes, fill/run scheduling,
// training-to-tracking step-size selection and double-buffered I/Q tap bank.
module fse_ctrl #(
  parameter int NUM_TAPS       = 11,
  parameter int NBT_TAPS       = 28,
  parameter int NBF_TAPS       = 25,
  parameter int CLK_PER_SAMPLE = 2,
  parameter int TRAIN_SYMS     = 1024,
  parameter int NB_ADDR        = 4
) (
  input  logic                         clk,
  input  logic                         i_reset,
  input  logic                         i_start,
  input  logic                         i_stop,
  input  logic                         i_phase_sel,
  input  logic                         i_cfg_we,
  input  logic [NB_ADDR-1:0]           i_cfg_addr,
  input  logic [NBT_TAPS-1:0]          i_cfg_tap_I,
  input  logic [NBT_TAPS-1:0]          i_cfg_tap_Q,
  input  logic                         i_cfg_commit,
  output logic                         o_fse_en,
  output logic                         o_sym_strobe,
  output logic                         o_out_valid,
  output logic                         o_adapt_en,
  output logic                         o_mu_sel,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_I,
  output logic [NUM_TAPS*NBT_TAPS-1:0] o_taps_Q,
  output logic                         o_commit_pend,
  output logic [1:0]                   o_state
);

  localparam int CNT_W  = (CLK_PER_SAMPLE > 1) ? $clog2(CLK_PER_SAMPLE) : 1;
  localparam int FILL_W = $clog2(NUM_TAPS + 1);
  localparam int SYM_W  = $clog2(TRAIN_SYMS + 1);
  localparam int CENTER = NUM_TAPS / 2;

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(CLK_PER_SAMPLE - 1);
  localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(NUM_TAPS - 1);
  localparam logic [SYM_W-1:0]  SYM_SAT   = SYM_W'(TRAIN_SYMS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2
  } state_t;

  typedef logic [NBT_TAPS-1:0] tap_t;

  // Centre real tap is unity, everything else zero: a pass-through filter.
  function automatic tap_t reset_tap_i(input int j);
    return (j == CENTER) ? (tap_t'(1) << NBF_TAPS) : '0;
  endfunction

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  logic              ph, ph_nxt;
  logic [FILL_W-1:0] fill_cnt, fill_nxt;
  logic [SYM_W-1:0]  sym_cnt, sym_nxt;
  logic              fse_en, fse_en_nxt;
  logic              sym_strobe, sym_strobe_nxt;
  logic              out_valid, out_valid_nxt;
  logic              mu_sel, mu_sel_nxt;
  logic              commit_pend, commit_pend_nxt;
  logic              commit_req, apply;

  tap_t shadow_i [NUM_TAPS];
  tap_t shadow_q [NUM_TAPS];
  tap_t active_i [NUM_TAPS];
  tap_t active_q [NUM_TAPS];
  tap_t shadow_i_nxt [NUM_TAPS];
  tap_t shadow_q_nxt [NUM_TAPS];
  tap_t active_i_nxt [NUM_TAPS];
  tap_t active_q_nxt [NUM_TAPS];

  always_comb begin
    // NOTE: every signal gets a default before any branch so no path leaves one unassigned (no latches).
    state_nxt    = state;
    cnt_nxt      = cnt;
    ph_nxt       = ph;
    fill_nxt     = fill_cnt;
    sym_nxt      = sym_cnt;
    out_valid_nxt = 1'b0;
    shadow_i_nxt = shadow_i;
    shadow_q_nxt = shadow_q;
    active_i_nxt = active_i;
    active_q_nxt = active_q;

    for (int j = 0; j < NUM_TAPS; j++) begin
      if (i_cfg_we && (int'(i_cfg_addr) == j)) begin
        shadow_i_nxt[j] = i_cfg_tap_I;
        shadow_q_nxt[j] = i_cfg_tap_Q;
      end
    end

    // Taps swap only when the delay line is idle or shifting, using the
    // shadow as it stands after any same-cycle write.
    commit_req      = commit_pend | i_cfg_commit;
    apply           = commit_req & ((state == IDLE) | fse_en);
    commit_pend_nxt = commit_req & ~apply;
    if (apply) begin
      active_i_nxt = shadow_i_nxt;
      active_q_nxt = shadow_q_nxt;
    end

    case (state)
      IDLE: begin
        cnt_nxt  = '0;
        ph_nxt   = 1'b0;
        fill_nxt = '0;
        sym_nxt  = '0;
        if (i_start && !i_stop) state_nxt = FILL;
      end
      FILL, RUN: begin
        if (i_stop) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          ph_nxt    = 1'b0;
          fill_nxt  = '0;
          sym_nxt   = '0;
        end else begin
          cnt_nxt = fse_en ? '0 : cnt + CNT_W'(1);
          if (fse_en) ph_nxt = ~ph;
          if (state == FILL && fse_en) begin
            if (fill_cnt == FILL_LAST) begin
              state_nxt = RUN;
              fill_nxt  = '0;
            end else begin
              fill_nxt = fill_cnt + FILL_W'(1);
            end
          end
          if (state == RUN) begin
            out_valid_nxt = sym_strobe;
            if (out_valid && sym_cnt != SYM_SAT) sym_nxt = sym_cnt + SYM_W'(1);
          end
        end
      end
      default: state_nxt = IDLE;
    endcase

    // Strobes are precomputed from next state so they leave the block as flops.
    fse_en_nxt     = (state_nxt != IDLE) && (cnt_nxt == CNT_LAST);
    sym_strobe_nxt = fse_en_nxt && (ph_nxt == i_phase_sel);
    mu_sel_nxt     = (sym_nxt == SYM_SAT);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (i_reset) begin
      state       <= IDLE;
      cnt         <= '0;
      ph          <= 1'b0;
      fill_cnt    <= '0;
      sym_cnt     <= '0;
      fse_en      <= 1'b0;
      sym_strobe  <= 1'b0;
      out_valid   <= 1'b0;
      mu_sel      <= 1'b0;
      commit_pend <= 1'b0;
      // NOTE: both tap banks are reset explicitly; the equalizer must start as a known pass-through.
      for (int j = 0; j < NUM_TAPS; j++) begin
        shadow_i[j] <= reset_tap_i(j);
        shadow_q[j] <= '0;
        active_i[j] <= reset_tap_i(j);
        active_q[j] <= '0;
      end
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      ph          <= ph_nxt;
      fill_cnt    <= fill_nxt;
      sym_cnt     <= sym_nxt;
      fse_en      <= fse_en_nxt;
      sym_strobe  <= sym_strobe_nxt;
      out_valid   <= out_valid_nxt;
      mu_sel      <= mu_sel_nxt;
      commit_pend <= commit_pend_nxt;
      shadow_i    <= shadow_i_nxt;
      shadow_q    <= shadow_q_nxt;
      active_i    <= active_i_nxt;
      active_q    <= active_q_nxt;
    end
  end

  assign o_fse_en      = fse_en;
  assign o_sym_strobe  = sym_strobe;
  assign o_out_valid   = out_valid;
  assign o_adapt_en    = out_valid;
  assign o_mu_sel      = mu_sel;
  assign o_commit_pend = commit_pend;
  assign o_state       = state;

  always_comb begin
    o_taps_I = '0;
    o_taps_Q = '0;
    for (int j = 0; j < NUM_TAPS; j++) begin
      o_taps_I[j*NBT_TAPS +: NBT_TAPS] = active_i[j];
      o_taps_Q[j*NBT_TAPS +: NBT_TAPS] = active_q[j];
    end
  end

endmodule
